// File: rtl/cpu54_pkg.sv
// Shared definitions for the 54-instruction MIPS core: reset PC, instruction
// field codes, decoded_instr bit positions and the fetch FSM state encoding.
package cpu54_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam int          N_INSTR          = 54;

  // Primary opcodes, ir[31:26]
  localparam logic [5:0] OP_SPECIAL  = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL      = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU    = 6'h0B, OP_ANDI   = 6'h0C, OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E, OP_LUI    = 6'h0F, OP_COP0  = 6'h10;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C, OP_LB     = 6'h20, OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW       = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB       = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2B;

  // SPECIAL funct codes, ir[5:0]
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV  = 6'h06, FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BRK  = 6'h0D, FN_MFHI  = 6'h10, FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12, FN_MTLO  = 6'h13, FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU    = 6'h1B;
  localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR   = 6'h27, FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B, FN_TEQ   = 6'h34;

  // REGIMM rt, COP0 rs/funct and SPECIAL2 funct codes
  localparam logic [4:0] RT_BGEZ  = 5'h01;
  localparam logic [4:0] RS_MFC0  = 5'h00, RS_MTC0 = 5'h04, RS_CO = 5'h10;
  localparam logic [5:0] FN_ERET  = 6'h18;
  localparam logic [5:0] FN2_CLZ  = 6'h20;

  // Bit positions inside decoded_instr
  localparam int I_ADD  = 0,  I_ADDU  = 1,  I_SUB   = 2,  I_SUBU   = 3,  I_AND   = 4;
  localparam int I_OR   = 5,  I_XOR   = 6,  I_NOR   = 7,  I_SLT    = 8,  I_SLTU  = 9;
  localparam int I_SLL  = 10, I_SRL   = 11, I_SRA   = 12, I_SLLV   = 13, I_SRLV  = 14;
  localparam int I_SRAV = 15, I_JR    = 16, I_ADDI  = 17, I_ADDIU  = 18, I_ANDI  = 19;
  localparam int I_ORI  = 20, I_XORI  = 21, I_LUI   = 22, I_LW     = 23, I_SW    = 24;
  localparam int I_BEQ  = 25, I_BNE   = 26, I_SLTI  = 27, I_SLTIU  = 28, I_J     = 29;
  localparam int I_JAL  = 30, I_DIV   = 31, I_DIVU  = 32, I_MULT   = 33, I_MULTU = 34;
  localparam int I_BGEZ = 35, I_JALR  = 36, I_LBU   = 37, I_LHU    = 38, I_LB    = 39;
  localparam int I_LH   = 40, I_SB    = 41, I_SH    = 42, I_BREAK  = 43, I_SYSCALL = 44;
  localparam int I_ERET = 45, I_MFHI  = 46, I_MFLO  = 47, I_MTHI   = 48, I_MTLO  = 49;
  localparam int I_MFC0 = 50, I_MTC0  = 51, I_CLZ   = 52, I_TEQ    = 53;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DEC   = 2'd2,
    S_VALID = 2'd3
  } fd_state_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational one-hot decode of an instruction word; illegal flags a word
// that matches none of the 54 supported instructions.
module instr_decoder
  import cpu54_pkg::*;
(
  input  logic [31:0]        ir,
  output logic [N_INSTR-1:0] onehot,
  output logic               illegal
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       unused_bits;

  assign op          = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign funct       = ir[5:0];
  assign unused_bits = ^ir[15:6];

  always_comb begin
    onehot = '0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD:     onehot[I_ADD]     = 1'b1;
          FN_ADDU:    onehot[I_ADDU]    = 1'b1;
          FN_SUB:     onehot[I_SUB]     = 1'b1;
          FN_SUBU:    onehot[I_SUBU]    = 1'b1;
          FN_AND:     onehot[I_AND]     = 1'b1;
          FN_OR:      onehot[I_OR]      = 1'b1;
          FN_XOR:     onehot[I_XOR]     = 1'b1;
          FN_NOR:     onehot[I_NOR]     = 1'b1;
          FN_SLT:     onehot[I_SLT]     = 1'b1;
          FN_SLTU:    onehot[I_SLTU]    = 1'b1;
          FN_SLL:     onehot[I_SLL]     = 1'b1;
          FN_SRL:     onehot[I_SRL]     = 1'b1;
          FN_SRA:     onehot[I_SRA]     = 1'b1;
          FN_SLLV:    onehot[I_SLLV]    = 1'b1;
          FN_SRLV:    onehot[I_SRLV]    = 1'b1;
          FN_SRAV:    onehot[I_SRAV]    = 1'b1;
          FN_JR:      onehot[I_JR]      = 1'b1;
          FN_JALR:    onehot[I_JALR]    = 1'b1;
          FN_DIV:     onehot[I_DIV]     = 1'b1;
          FN_DIVU:    onehot[I_DIVU]    = 1'b1;
          FN_MULT:    onehot[I_MULT]    = 1'b1;
          FN_MULTU:   onehot[I_MULTU]   = 1'b1;
          FN_BRK:     onehot[I_BREAK]   = 1'b1;
          FN_SYSCALL: onehot[I_SYSCALL] = 1'b1;
          FN_MFHI:    onehot[I_MFHI]    = 1'b1;
          FN_MFLO:    onehot[I_MFLO]    = 1'b1;
          FN_MTHI:    onehot[I_MTHI]    = 1'b1;
          FN_MTLO:    onehot[I_MTLO]    = 1'b1;
          FN_TEQ:     onehot[I_TEQ]     = 1'b1;
          default: ;
        endcase
      end
      OP_REGIMM:   if (rt == RT_BGEZ) onehot[I_BGEZ] = 1'b1;
      OP_SPECIAL2: if (funct == FN2_CLZ) onehot[I_CLZ] = 1'b1;
      OP_COP0: begin
        // eret lives in the CO space (rs=0x10) and is told apart by funct
        if (rs == RS_MFC0)                         onehot[I_MFC0] = 1'b1;
        else if (rs == RS_MTC0)                    onehot[I_MTC0] = 1'b1;
        else if (rs == RS_CO && funct == FN_ERET)  onehot[I_ERET] = 1'b1;
      end
      OP_ADDI:  onehot[I_ADDI]  = 1'b1;
      OP_ADDIU: onehot[I_ADDIU] = 1'b1;
      OP_ANDI:  onehot[I_ANDI]  = 1'b1;
      OP_ORI:   onehot[I_ORI]   = 1'b1;
      OP_XORI:  onehot[I_XORI]  = 1'b1;
      OP_LUI:   onehot[I_LUI]   = 1'b1;
      OP_LW:    onehot[I_LW]    = 1'b1;
      OP_SW:    onehot[I_SW]    = 1'b1;
      OP_BEQ:   onehot[I_BEQ]   = 1'b1;
      OP_BNE:   onehot[I_BNE]   = 1'b1;
      OP_SLTI:  onehot[I_SLTI]  = 1'b1;
      OP_SLTIU: onehot[I_SLTIU] = 1'b1;
      OP_J:     onehot[I_J]     = 1'b1;
      OP_JAL:   onehot[I_JAL]   = 1'b1;
      OP_LBU:   onehot[I_LBU]   = 1'b1;
      OP_LHU:   onehot[I_LHU]   = 1'b1;
      OP_LB:    onehot[I_LB]    = 1'b1;
      OP_LH:    onehot[I_LH]    = 1'b1;
      OP_SB:    onehot[I_SB]    = 1'b1;
      OP_SH:    onehot[I_SH]    = 1'b1;
      default: ;
    endcase
  end

  assign illegal = ~|onehot;

endmodule

// File: rtl/fetch_decode_unit.sv
// Front end of the multi-cycle core: PC register, single-word instruction
// fetch into the IR, and a registered one-hot decode for the controller.
module fetch_decode_unit
  import cpu54_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic               pc_ena,
  input  logic [31:0]        pc_next,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        npc,
  output logic [31:0]        ir,
  output logic [N_INSTR-1:0] decoded_instr,
  output logic               instr_valid,
  output logic               illegal,
  output logic               fetch_fault,
  output logic               busy,
  output fd_state_t          state_dbg
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  fd_state_t            state;
  logic [CW-1:0]        wait_cnt;
  logic [N_INSTR-1:0]   dec_onehot;
  logic                 dec_illegal;
  logic                 unused_bits;

  assign unused_bits = ^pc_next[1:0];

  instr_decoder u_decoder (
    .ir      (ir),
    .onehot  (dec_onehot),
    .illegal (dec_illegal)
  );

  // The PC is owned by the controller; this block never advances it itself.
  always_ff @(posedge clk) begin
    if (rst)         pc <= RESET_PC;
    else if (pc_ena) pc <= {pc_next[31:2], 2'b00};
  end

  assign npc       = pc + 32'd4;
  assign busy      = (state == S_REQ) || (state == S_DEC);
  assign state_dbg = state;

  // Memory handshake: imem_req stays high with imem_addr frozen until a cycle
  // with imem_ready=1 transfers imem_rdata; ready seen while req is low is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      ir            <= '0;
      decoded_instr <= '0;
      instr_valid   <= 1'b0;
      illegal       <= 1'b0;
      fetch_fault   <= 1'b0;
    end else begin
      fetch_fault <= 1'b0;
      case (state)
        S_IDLE, S_VALID: begin
          if (fetch_req) begin
            imem_addr   <= pc;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= S_REQ;
          end
        end
        S_REQ: begin
          if (imem_ready) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DEC;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            fetch_fault <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DEC: begin
          decoded_instr <= dec_onehot;
          illegal       <= dec_illegal;
          instr_valid   <= 1'b1;
          state         <= S_VALID;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed fetch scenarios plus randomized fetches
// against a table-driven decode model and a timing/PC model.
module tb_fetch_decode_unit;
  import cpu54_pkg::*;

  localparam int          TB_TIMEOUT = 8;
  localparam logic [31:0] TB_RST_PC  = 32'h0040_0000;

  logic        clk, rst, fetch_req, pc_ena, imem_req, imem_ready;
  logic [31:0] pc_next, imem_addr, imem_rdata, pc, npc, ir;
  logic [53:0] decoded_instr;
  logic        instr_valid, illegal, fetch_fault, busy;
  fd_state_t   state_dbg;

  fetch_decode_unit #(.RESET_PC(TB_RST_PC), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .pc_ena(pc_ena), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .npc(npc), .ir(ir),
    .decoded_instr(decoded_instr), .instr_valid(instr_valid), .illegal(illegal),
    .fetch_fault(fetch_fault), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Each entry: {opcode, match kind, field}; kind 0 opcode only, 1 funct,
  // 2 rt, 3 rs, 4 rs=0x10 plus funct. Entry index = decoded_instr bit.
  logic [14:0] ref_tab [54] = '{
    {6'h00,3'd1,6'h20}, {6'h00,3'd1,6'h21}, {6'h00,3'd1,6'h22}, {6'h00,3'd1,6'h23},
    {6'h00,3'd1,6'h24}, {6'h00,3'd1,6'h25}, {6'h00,3'd1,6'h26}, {6'h00,3'd1,6'h27},
    {6'h00,3'd1,6'h2A}, {6'h00,3'd1,6'h2B}, {6'h00,3'd1,6'h00}, {6'h00,3'd1,6'h02},
    {6'h00,3'd1,6'h03}, {6'h00,3'd1,6'h04}, {6'h00,3'd1,6'h06}, {6'h00,3'd1,6'h07},
    {6'h00,3'd1,6'h08}, {6'h08,3'd0,6'h00}, {6'h09,3'd0,6'h00}, {6'h0C,3'd0,6'h00},
    {6'h0D,3'd0,6'h00}, {6'h0E,3'd0,6'h00}, {6'h0F,3'd0,6'h00}, {6'h23,3'd0,6'h00},
    {6'h2B,3'd0,6'h00}, {6'h04,3'd0,6'h00}, {6'h05,3'd0,6'h00}, {6'h0A,3'd0,6'h00},
    {6'h0B,3'd0,6'h00}, {6'h02,3'd0,6'h00}, {6'h03,3'd0,6'h00}, {6'h00,3'd1,6'h1A},
    {6'h00,3'd1,6'h1B}, {6'h00,3'd1,6'h18}, {6'h00,3'd1,6'h19}, {6'h01,3'd2,6'h01},
    {6'h00,3'd1,6'h09}, {6'h24,3'd0,6'h00}, {6'h25,3'd0,6'h00}, {6'h20,3'd0,6'h00},
    {6'h21,3'd0,6'h00}, {6'h28,3'd0,6'h00}, {6'h29,3'd0,6'h00}, {6'h00,3'd1,6'h0D},
    {6'h00,3'd1,6'h0C}, {6'h10,3'd4,6'h18}, {6'h00,3'd1,6'h10}, {6'h00,3'd1,6'h12},
    {6'h00,3'd1,6'h11}, {6'h00,3'd1,6'h13}, {6'h10,3'd3,6'h00}, {6'h10,3'd3,6'h04},
    {6'h1C,3'd1,6'h20}, {6'h00,3'd1,6'h34}
  };

  // Returns {illegal, onehot}
  function automatic logic [54:0] ref_decode(input logic [31:0] w);
    logic [53:0] hot;
    hot = '0;
    for (int i = 0; i < 54; i++) begin
      logic [5:0] op;
      logic [2:0] kind;
      logic [5:0] f;
      logic       hit;
      {op, kind, f} = ref_tab[i];
      case (kind)
        3'd0:    hit = (w[31:26] == op);
        3'd1:    hit = (w[31:26] == op) && (w[5:0] == f);
        3'd2:    hit = (w[31:26] == op) && (w[20:16] == f[4:0]);
        3'd3:    hit = (w[31:26] == op) && (w[25:21] == f[4:0]);
        3'd4:    hit = (w[31:26] == op) && (w[25:21] == 5'h10) && (w[5:0] == f);
        default: hit = 1'b0;
      endcase
      hot[i] = hit;
    end
    return {~|hot, hot};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [5:0]  op, f;
    logic [2:0]  kind;
    w = $urandom;
    if ($urandom_range(0, 3) != 0) begin
      {op, kind, f} = ref_tab[$urandom_range(0, 53)];
      w[31:26] = op;
      case (kind)
        3'd1:    w[5:0] = f;
        3'd2:    w[20:16] = f[4:0];
        3'd3:    w[25:21] = f[4:0];
        3'd4:    begin w[25:21] = 5'h10; w[5:0] = f; end
        default: ;
      endcase
    end
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  logic [54:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] last_ir;
  bit          rand_mode;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_step();
    @(posedge clk);
    #1;
    if (pc_ena && !rst) exp_pc = pc_next & ~32'h3;
    pc_ena = 1'b0;
  endtask

  task automatic rand_pc_drive();
    if (rand_mode && $urandom_range(0, 3) == 0) begin
      pc_ena  = 1'b1;
      pc_next = $urandom;
    end
  endtask

  task automatic do_fetch(input logic [31:0] word, input int delay,
                          input bit mid_en, input logic [31:0] mid_pc);
    logic [31:0] addr;
    logic [54:0] exp, got;
    int          cycles, n;
    addr = exp_pc;
    exp  = ref_decode(word);
    fetch_req = 1'b1;
    rand_pc_drive();
    drive_step();
    fetch_req = 1'b0;
    check_val("req_start", 64'(imem_req), 64'd1);
    check_val("addr_start", 64'(imem_addr), 64'(addr));
    cycles = 1;
    n = 0;
    while (instr_valid !== 1'b1 && cycles < 40) begin
      check_val("pc", 64'(pc), 64'(exp_pc));
      check_val("npc", 64'(npc), 64'(exp_pc + 32'd4));
      fetch_req = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      if (imem_req === 1'b1) begin
        check_val("addr_stable", 64'(imem_addr), 64'(addr));
        imem_ready = (n == delay);
        imem_rdata = (n == delay) ? word : $urandom;
        if (n == delay) exp_q.push_back(exp);
        if (n == 0 && mid_en) begin
          pc_ena  = 1'b1;
          pc_next = mid_pc;
        end else begin
          rand_pc_drive();
        end
        n++;
      end else begin
        imem_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        imem_rdata = $urandom;
        rand_pc_drive();
      end
      drive_step();
      cycles++;
    end
    fetch_req  = 1'b0;
    imem_ready = 1'b0;
    check_val("latency", 64'(cycles), 64'(delay + 3));
    check_val("req_cycles", 64'(n), 64'(delay + 1));
    check_val("instr_valid", 64'(instr_valid), 64'd1);
    if (exp_q.size() != 0) begin
      got = exp_q.pop_front();
      check_val("decoded", 64'(decoded_instr), 64'(got[53:0]));
      check_val("illegal", 64'(illegal), 64'(got[54]));
    end else begin
      check_val("sb_pending", 64'(exp_q.size()), 64'd1);
    end
    check_val("ir", 64'(ir), 64'(word));
    check_val("busy_valid", 64'(busy), 64'd0);
    last_ir = word;
  endtask

  task automatic do_timeout();
    int k;
    fetch_req = 1'b1;
    drive_step();
    fetch_req  = 1'b0;
    imem_ready = 1'b0;
    k = 0;
    while (fetch_fault !== 1'b1 && k < 4 * TB_TIMEOUT) begin
      drive_step();
      k++;
    end
    check_val("fault_time", 64'(k), 64'(TB_TIMEOUT));
    check_val("fault_state", 64'(state_dbg), 64'(S_IDLE));
    check_val("fault_valid", 64'(instr_valid), 64'd0);
    check_val("fault_ir", 64'(ir), 64'(last_ir));
    check_val("fault_req", 64'(imem_req), 64'd0);
    drive_step();
    check_val("fault_pulse", 64'(fetch_fault), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; fetch_req = 1'b0; pc_ena = 1'b0; pc_next = '0;
    imem_ready = 1'b0; imem_rdata = '0; rand_mode = 1'b0;
    exp_pc = TB_RST_PC; last_ir = '0;
    repeat (2) drive_step();
    check_val("rst_pc", 64'(pc), 64'h0040_0000);
    check_val("rst_npc", 64'(npc), 64'h0040_0004);
    check_val("rst_valid", 64'(instr_valid), 64'd0);
    check_val("rst_req", 64'(imem_req), 64'd0);
    check_val("rst_decoded", 64'(decoded_instr), 64'd0);
    check_val("rst_state", 64'(state_dbg), 64'(S_IDLE));
    check_val("rst_fault", 64'(fetch_fault), 64'd0);
    rst = 1'b0;
    drive_step();

    do_fetch(32'h0043_0820, 0, 1'b0, '0);
    check_val("add_onehot", 64'(decoded_instr), 64'h1);
    do_fetch(32'h3C01_1234, 4, 1'b0, '0);
    check_val("lui_onehot", 64'(decoded_instr), 64'h1 << 22);
    do_fetch(32'hFC00_0000, 1, 1'b0, '0);
    check_val("illegal_flag", 64'(illegal), 64'd1);
    check_val("illegal_onehot", 64'(decoded_instr), 64'd0);
    do_fetch(32'h0000_0000, 0, 1'b0, '0);
    check_val("nop_sll", 64'(decoded_instr), 64'h1 << 10);

    do_timeout();

    do_fetch(32'h2402_0005, 2, 1'b1, 32'h0040_0103);
    check_val("pc_mid", 64'(pc), 64'h0040_0100);
    fetch_req = 1'b1;
    drive_step();
    fetch_req = 1'b0;
    check_val("addr_new_pc", 64'(imem_addr), 64'h0040_0100);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0008;
    exp_q.push_back(ref_decode(32'h0000_0008));
    drive_step();
    imem_ready = 1'b0;
    drive_step();
    check_val("jr_valid", 64'(instr_valid), 64'd1);
    check_val("jr_decoded", 64'(decoded_instr), 64'(exp_q.pop_front()));
    last_ir = 32'h0000_0008;

    pc_ena = 1'b1; pc_next = 32'hFFFF_FFFF;
    drive_step();
    check_val("wrap_pc", 64'(pc), 64'hFFFF_FFFC);
    check_val("wrap_npc", 64'(npc), 64'd0);

    // reset arriving while a fetch is outstanding
    fetch_req = 1'b1;
    drive_step();
    fetch_req = 1'b0;
    check_val("mid_req", 64'(imem_req), 64'd1);
    rst = 1'b1;
    drive_step();
    check_val("mid_rst_req", 64'(imem_req), 64'd0);
    rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0043_0820;
    repeat (2) drive_step();
    imem_ready = 1'b0;
    check_val("mid_rst_state", 64'(state_dbg), 64'(S_IDLE));
    check_val("mid_rst_valid", 64'(instr_valid), 64'd0);
    check_val("mid_rst_ir", 64'(ir), 64'd0);
    exp_pc = TB_RST_PC;
    last_ir = '0;

    rand_mode = 1'b1;
    for (int t = 0; t < 150; t++) begin
      do_fetch(rand_word(), $urandom_range(0, TB_TIMEOUT - 2), 1'b0, '0);
      if ($urandom_range(0, 15) == 0) do_timeout();
      repeat ($urandom_range(0, 2)) begin
        rand_pc_drive();
        drive_step();
      end
    end

    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
